player_id_auth_param: RTL and testbench

Parametrised player-ID authenticator for the Morse game front end. It collects `ID_DIGITS` keypad digits, first checks the code against a fixed guest code, then searches an external synchronous ID ROM of `NUM_IDS` entries. It reports the matching player index, or guest status. Repeated failures are counted, and a timed lockout is enforced after `MAX_FAILS` consecutive failures. It supersedes the fixed 4-digit/8-player checker and sits between the digit-entry logic and the game controller.

---
 rtl/player_id_auth_param_if.sv | 11 +
 rtl/player_id_auth_param.sv | 172 +++++++++++++++++
 tb/tb_player_id_auth_param.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_id_auth_param_if.sv
// rtl/player_id_auth_param_if.sv - ID ROM read bus between the authenticator and its code ROM
interface player_id_auth_param_if #(
    parameter int ADDR_W = 5,
    parameter int CODE_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [CODE_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/player_id_auth_param.sv
// rtl/player_id_auth_param.sv - keypad player-ID authenticator: guest code, ROM search, failure lockout
module player_id_auth_param #(
    parameter int DIGIT_W     = 4,
    parameter int ID_DIGITS   = 4,
    parameter int NUM_IDS     = 8,
    parameter int IDX_W       = 3,
    parameter int ADDR_W      = 5,
    parameter int ROM_BASE    = 0,
    parameter logic [DIGIT_W*ID_DIGITS-1:0] GUEST_CODE = '0,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int CODE_W     = DIGIT_W * ID_DIGITS,
    localparam int FC_W       = $clog2(MAX_FAILS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGIT_W-1:0]     user_digit,
    input  logic                   user_load,
    input  logic                   logout,
    player_id_auth_param_if.master rom,
    output logic                   matched,
    output logic [IDX_W-1:0]       player_id,
    output logic                   is_guest,
    output logic                   busy,
    output logic                   fail_pulse,
    output logic                   locked,
    output logic [FC_W-1:0]        fail_count
);
    localparam int DCNT_W = $clog2(ID_DIGITS + 1);
    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOOKUP, S_CMP, S_AUTH, S_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   pid_q, pid_d;
    logic               matched_q, matched_d;
    logic               guest_q, guest_d;
    logic               fpulse_q, fpulse_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        dcnt_d    = dcnt_q;
        idx_d     = idx_q;
        fcnt_d    = fcnt_q;
        timer_d   = timer_q;
        pid_d     = pid_q;
        matched_d = matched_q;
        guest_d   = guest_q;
        fpulse_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // logout outranks a simultaneous digit so a half-typed code never survives
                if (logout) begin
                    code_d = '0;
                    dcnt_d = '0;
                end else if (user_load) begin
                    code_d = (code_q << DIGIT_W) | CODE_W'(user_digit);
                    if (dcnt_q == DCNT_W'(ID_DIGITS - 1)) state_d = S_CHECK;
                    else                                  dcnt_d  = dcnt_q + DCNT_W'(1);
                end
            end
            S_CHECK: begin
                if (logout) begin
                    state_d = S_IDLE;
                end else if (code_q == GUEST_CODE) begin
                    state_d   = S_AUTH;
                    matched_d = 1'b1;
                    guest_d   = 1'b1;
                    pid_d     = '0;
                end else begin
                    idx_d   = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = logout ? S_IDLE : S_CMP;
            S_CMP: begin
                if (logout) begin
                    state_d = S_IDLE;
                end else if (rom.rom_data == code_q) begin
                    state_d   = S_AUTH;
                    matched_d = 1'b1;
                    guest_d   = 1'b0;
                    pid_d     = idx_q;
                    fcnt_d    = '0;
                end else if (32'(idx_q) < NUM_IDS - 1) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOOKUP;
                end else begin
                    fpulse_d = 1'b1;
                    fcnt_d   = fcnt_q + FC_W'(1);
                    if (32'(fcnt_q) + 32'd1 == 32'(MAX_FAILS)) begin
                        state_d = S_LOCKED;
                        timer_d = TMR_W'(LOCK_CYCLES);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_AUTH: begin
                if (logout) begin
                    state_d   = S_IDLE;
                    matched_d = 1'b0;
                    guest_d   = 1'b0;
                    pid_d     = '0;
                end
            end
            S_LOCKED: begin
                // the timer counts the remaining locked cycles including the current one
                if (timer_q <= TMR_W'(1)) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            code_d = '0;
            dcnt_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q    <= '0;
            dcnt_q    <= '0;
            idx_q     <= '0;
            fcnt_q    <= '0;
            timer_q   <= '0;
            pid_q     <= '0;
            matched_q <= 1'b0;
            guest_q   <= 1'b0;
            fpulse_q  <= 1'b0;
        end else begin
            code_q    <= code_d;
            dcnt_q    <= dcnt_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            timer_q   <= timer_d;
            pid_q     <= pid_d;
            matched_q <= matched_d;
            guest_q   <= guest_d;
            fpulse_q  <= fpulse_d;
        end
    end

    always_comb begin
        busy         = (state_q == S_CHECK) || (state_q == S_LOOKUP) || (state_q == S_CMP);
        locked       = (state_q == S_LOCKED);
        rom.rom_addr = ADDR_W'(ROM_BASE) + ADDR_W'(idx_q);
        matched      = matched_q;
        player_id    = pid_q;
        is_guest     = guest_q;
        fail_pulse   = fpulse_q;
        fail_count   = fcnt_q;
    end
endmodule

// File: tb/tb_player_id_auth_param.sv
// tb/tb_player_id_auth_param.sv - randomized self-checking bench for player_id_auth_param
module tb_player_id_auth_param;
    localparam int N1    = 8;
    localparam int N2    = 16;
    localparam int BASE2 = 3;
    localparam int MAXF  = 3;
    localparam int LOCKC = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2;
    logic [3:0] user_digit1, user_digit2;
    logic       user_load1, user_load2, logout1, logout2;
    logic       matched1, guest1, busy1, fpulse1, locked1;
    logic [2:0] pid1;
    logic [1:0] fcnt1;
    logic       matched2, guest2, busy2, fpulse2, locked2;
    logic [3:0] pid2;
    logic [1:0] fcnt2;

    player_id_auth_param_if #(.ADDR_W(5), .CODE_W(16)) rif1 ();
    player_id_auth_param_if #(.ADDR_W(5), .CODE_W(24)) rif2 ();

    logic [15:0] rom1 [0:31];
    logic [23:0] rom2 [0:31];

    always @(posedge clk) begin
        rif1.rom_data <= rom1[rif1.rom_addr];
        rif2.rom_data <= rom2[rif2.rom_addr];
    end

    player_id_auth_param dut1 (
        .clk(clk), .rst(rst1), .user_digit(user_digit1), .user_load(user_load1),
        .logout(logout1), .rom(rif1), .matched(matched1), .player_id(pid1),
        .is_guest(guest1), .busy(busy1), .fail_pulse(fpulse1), .locked(locked1),
        .fail_count(fcnt1)
    );

    player_id_auth_param #(
        .DIGIT_W(4), .ID_DIGITS(6), .NUM_IDS(N2), .IDX_W(4), .ADDR_W(5),
        .ROM_BASE(BASE2), .GUEST_CODE(24'h000000), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC)
    ) dut2 (
        .clk(clk), .rst(rst2), .user_digit(user_digit2), .user_load(user_load2),
        .logout(logout2), .rom(rif2), .matched(matched2), .player_id(pid2),
        .is_guest(guest2), .busy(busy2), .fail_pulse(fpulse2), .locked(locked2),
        .fail_count(fcnt2)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int fails_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome from the rules: guest first, else lowest matching index, else failure.
    function automatic void predict(input logic [15:0] code, output int kind,
                                    output int edge_n, output int idx);
        kind   = 2;
        edge_n = 2 * N1 + 1;
        idx    = 0;
        if (code == 16'h0000) begin
            kind   = 0;
            edge_n = 1;
        end else begin
            for (int i = N1 - 1; i >= 0; i--) begin
                if (rom1[5'(i)] == code) begin
                    kind   = 1;
                    idx    = i;
                    edge_n = 3 + 2 * i;
                end
            end
        end
    endfunction

    task automatic load_code1(input logic [15:0] code, input int gap_max);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat ($urandom_range(gap_max, 0)) tick();
            user_digit1 = code[15 - 4 * d -: 4];
            user_load1  = 1'b1;
            tick();
            user_load1  = 1'b0;
        end
    endtask

    task automatic attempt(input logic [15:0] code);
        int kind, edge_n, idx;
        bit lock_ok;
        predict(code, kind, edge_n, idx);
        load_code1(code, 2);
        chk("busy_after_e0", 32'(busy1), 1);
        for (int k = 1; k <= edge_n; k++) begin
            tick();
            if (k < edge_n) begin
                chk("busy_search", 32'(busy1), 1);
                chk("no_early_match", 32'(matched1), 0);
            end
        end
        if (kind != 2) begin
            if (kind == 1) fails_m = 0;
            chk("matched", 32'(matched1), 1);
            chk("player_id", 32'(pid1), 32'(idx));
            chk("is_guest", 32'(guest1), 32'(kind == 0));
            chk("busy_auth", 32'(busy1), 0);
            chk("fail_count_auth", 32'(fcnt1), 32'(fails_m));
            for (int j = 0; j < 3; j++) begin
                user_digit1 = 4'($urandom);
                user_load1  = 1'($urandom_range(1, 0));
                tick();
            end
            user_load1 = 1'b0;
            chk("auth_hold_matched", 32'(matched1), 1);
            chk("auth_hold_pid", 32'(pid1), 32'(idx));
            logout1 = 1'b1;
            tick();
            logout1 = 1'b0;
            chk("logout_matched", 32'(matched1), 0);
            chk("logout_pid", 32'(pid1), 0);
            chk("logout_guest", 32'(guest1), 0);
        end else begin
            fails_m++;
            chk("fail_pulse", 32'(fpulse1), 1);
            chk("fail_count", 32'(fcnt1), 32'(fails_m));
            chk("fail_no_match", 32'(matched1), 0);
            chk("locked_on_fail", 32'(locked1), 32'(fails_m == MAXF));
            if (fails_m < MAXF) begin
                tick();
                chk("fail_pulse_width", 32'(fpulse1), 0);
            end else begin
                lock_ok = 1'b1;
                for (int j = 1; j <= LOCKC; j++) begin
                    user_digit1 = 4'($urandom);
                    user_load1  = 1'($urandom_range(1, 0));
                    logout1     = 1'($urandom_range(1, 0));
                    tick();
                    if (j == 1) chk("fail_pulse_width", 32'(fpulse1), 0);
                    if (j < LOCKC && locked1 !== 1'b1) lock_ok = 1'b0;
                end
                user_load1 = 1'b0;
                logout1    = 1'b0;
                chk("locked_held", 32'(lock_ok), 1);
                chk("lock_released", 32'(locked1), 0);
                chk("fail_count_cleared", 32'(fcnt1), 0);
                fails_m = 0;
            end
        end
    endtask

    task automatic abort_search(input logic [15:0] code);
        int kind, edge_n, idx;
        predict(code, kind, edge_n, idx);
        load_code1(code, 1);
        repeat ($urandom_range(edge_n - 2, 0)) tick();
        logout1 = 1'b1;
        tick();
        logout1 = 1'b0;
        chk("abort_busy", 32'(busy1), 0);
        chk("abort_no_match", 32'(matched1), 0);
        chk("abort_no_fail", 32'(fpulse1), 0);
        chk("abort_fail_count", 32'(fcnt1), 32'(fails_m));
    endtask

    task automatic partial_logout(input int n);
        for (int d = 0; d < n; d++) begin
            user_digit1 = 4'($urandom);
            user_load1  = 1'b1;
            tick();
            user_load1  = 1'b0;
        end
        user_digit1 = 4'($urandom);
        user_load1  = 1'b1;
        logout1     = 1'b1;
        tick();
        user_load1  = 1'b0;
        logout1     = 1'b0;
        chk("partial_busy", 32'(busy1), 0);
    endtask

    task automatic load2(input logic [23:0] code);
        for (int d = 0; d < 6; d++) begin
            user_digit2 = code[23 - 4 * d -: 4];
            user_load2  = 1'b1;
            tick();
            user_load2  = 1'b0;
        end
    endtask

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        user_digit1 = '0; user_load1 = 1'b0; logout1 = 1'b0;
        user_digit2 = '0; user_load2 = 1'b0; logout2 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            do rom1[5'(i)] = 16'($urandom);
            while (rom1[5'(i)] == 16'h1234 || rom1[5'(i)] == 16'h9999 ||
                   rom1[5'(i)] == 16'h7777 || rom1[5'(i)] == 16'h0000);
            do rom2[5'(i)] = 24'($urandom);
            while (rom2[5'(i)] == 24'hABC123 || rom2[5'(i)] == 24'h555555 ||
                   rom2[5'(i)] == 24'h000000);
        end
        rom1[2] = 16'h1234;
        rom1[7] = 16'h7777;
        rom1[5] = rom1[3];
        rom2[BASE2 + 10] = 24'hABC123;

        repeat (3) tick();
        chk("rst_matched", 32'(matched1), 0);
        chk("rst_pid", 32'(pid1), 0);
        chk("rst_guest", 32'(guest1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_fail_pulse", 32'(fpulse1), 0);
        chk("rst_locked", 32'(locked1), 0);
        chk("rst_fail_count", 32'(fcnt1), 0);
        chk("rst_rom_addr", 32'(rif1.rom_addr), 0);
        chk("rst2_rom_addr", 32'(rif2.rom_addr), BASE2);
        rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(busy1), 0);

        attempt(16'h1234);
        attempt(16'h0000);
        repeat (3) attempt(16'h9999);
        attempt(16'h9999);
        attempt(16'h1234);
        partial_logout(2);
        attempt(16'h1234);
        attempt(16'h7777);

        for (int it = 0; it < 30; it++) begin
            int sel;
            logic [15:0] c;
            sel = int'($urandom_range(9, 0));
            c   = rom1[5'($urandom_range(N1 - 1, 0))];
            case (sel)
                0:          attempt(16'h0000);
                1, 2, 3, 4: attempt(c);
                5, 6:       attempt(16'($urandom));
                7:          abort_search(c);
                default:    partial_logout(int'($urandom_range(3, 0)));
            endcase
        end

        load2(24'hABC123);
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 22) chk("d2_no_early_match", 32'(matched2), 0);
        end
        chk("d2_matched", 32'(matched2), 1);
        chk("d2_pid", 32'(pid2), 10);
        chk("d2_guest", 32'(guest2), 0);
        logout2 = 1'b1;
        tick();
        logout2 = 1'b0;
        chk("d2_logout", 32'(matched2), 0);

        load2(24'h555555);
        repeat (3) tick();
        chk("d2_busy_lookup", 32'(busy2), 1);
        chk("d2_rom_addr_lookup", 32'(rif2.rom_addr), BASE2 + 1);
        rst2 = 1'b0;
        #1;
        chk("d2_rst_busy", 32'(busy2), 0);
        chk("d2_rst_matched", 32'(matched2), 0);
        chk("d2_rst_pid", 32'(pid2), 0);
        chk("d2_rst_guest", 32'(guest2), 0);
        chk("d2_rst_fail_pulse", 32'(fpulse2), 0);
        chk("d2_rst_locked", 32'(locked2), 0);
        chk("d2_rst_fail_count", 32'(fcnt2), 0);
        chk("d2_rst_rom_addr", 32'(rif2.rom_addr), BASE2);
        #2;
        rst2 = 1'b1;
        repeat (2) tick();
        chk("d2_idle_after_rst", 32'(busy2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
